// File: rtl/instruction_loader.sv
// instruction_loader: turns a UART byte stream (16-bit big-endian word count
// followed by big-endian 32-bit words) into instruction-memory writes.
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   start          - one-cycle pulse arming the loader (from IDLE or DONE)
//   rx_valid       - one-cycle strobe qualifying rx_data
//   rx_data        - received byte
//   write_enable   - one-cycle memory write strobe per assembled word
//   address        - memory word address, counting up from 0
//   write_data     - assembled 32-bit word
//   busy           - high while a program is being loaded (CPU stall)
//   done           - high from completion until the next start or reset
//   error          - header word count exceeded MEM_SIZE
module instruction_loader #(
    parameter int MEM_SIZE   = 16000,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [15:0]           len_word;
    logic [ADDR_WIDTH-1:0] wcnt_inc;

    assign len_word = {len_q[15:8], rx_data};
    assign wcnt_inc = wcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_word;
                    if (len_word == 16'd0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if ({1'b0, len_word} > MEM_LIMIT) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        wcnt_d  = '0;
                        bcnt_d  = 2'd0;
                        last_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                // last_q marks the write cycle of the final word; the
                // stream is complete, so finish rather than take a byte.
                if (last_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    last_d  = 1'b0;
                end else if (rx_valid) begin
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], rx_data};
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {asm_q, rx_data};
                        addr_d  = wcnt_q;
                        wcnt_d  = wcnt_inc;
                        last_d  = (wcnt_inc == ADDR_WIDTH'(len_q));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            asm_q   <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign write_enable = we_q;
    assign address      = addr_q;
    assign write_data   = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: table vectors, hand sequences and random streams
// checked against a stream-level model of the loader.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        write_enable;
    logic [15:0] address;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        error;

    instruction_loader #(.MEM_SIZE(16000), .ADDR_WIDTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .write_enable(write_enable),
        .address(address),
        .write_data(write_data),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int done_rise, busy_rise, busy_fall, err_rise;
    logic done_p = 1'b0, busy_p = 1'b0, error_p = 1'b0;

    logic [7:0] stim[$];
    int         bcyc[$];
    int         s_cyc;

    // Observe one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (write_enable) begin
            wr_addr.push_back(address);
            wr_data.push_back(write_data);
            wr_cyc.push_back(cyc);
        end
        if (done && !done_p) done_rise = cyc;
        if (busy && !busy_p) busy_rise = cyc;
        if (!busy && busy_p) busy_fall = cyc;
        if (error && !error_p) err_rise = cyc;
        done_p = done;
        busy_p = busy;
        error_p = error;
    end

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        bcyc.delete();
        done_rise = -1;
        busy_rise = -1;
        busy_fall = -1;
        err_rise = -1;
    endtask

    task automatic do_start();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    // gap < 0 picks a random 0..2 idle cycles after each byte.
    task automatic send_range(int lo, int hi, int gap);
        int g;
        for (int i = lo; i < hi; i++) begin
            rx_valid = 1'b1;
            rx_data = stim[i];
            bcyc.push_back(cyc);
            tick();
            rx_valid = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) tick();
        end
    endtask

    task automatic idle_bytes(int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
            tick();
            rx_valid = 1'b0;
            tick();
        end
    endtask

    task automatic do_load(int gap);
        clear_mon();
        do_start();
        send_range(0, stim.size(), gap);
        repeat (4) tick();
    endtask

    // Expected behaviour derived from the byte stream and the cycle each
    // byte was presented: word i is bytes 2+4i..2+4i+3, written at address
    // i one cycle after its last byte; completion one cycle later.
    task automatic check_model(string nm);
        int n, k, ew;
        n = int'({stim[0], stim[1]});
        if (n > 16000) begin
            chk({nm, " nwr"}, wr_data.size(), 0);
            chk({nm, " error"}, error, 1);
            chk({nm, " busy"}, busy, 0);
            chk({nm, " done"}, done, 0);
            chk({nm, " err_t"}, err_rise, bcyc[1] + 1);
            chk({nm, " bfall_t"}, busy_fall, bcyc[1] + 1);
        end else begin
            chk({nm, " nwr"}, wr_data.size(), n);
            for (int i = 0; i < n && i < wr_data.size(); i++) begin
                k = 2 + 4 * i;
                chk($sformatf("%s addr%0d", nm, i), wr_addr[i], i);
                chk($sformatf("%s data%0d", nm, i), wr_data[i],
                    {stim[k], stim[k+1], stim[k+2], stim[k+3]});
                chk($sformatf("%s wcyc%0d", nm, i), wr_cyc[i],
                    bcyc[k+3] + 1);
            end
            ew = (n == 0) ? bcyc[1] + 1 : bcyc[2 + 4 * n - 1] + 2;
            chk({nm, " done_t"}, done_rise, ew);
            chk({nm, " bfall_t"}, busy_fall, ew);
            chk({nm, " done"}, done, 1);
            chk({nm, " busy"}, busy, 0);
            chk({nm, " error"}, error, 0);
        end
        chk({nm, " brise_t"}, busy_rise, s_cyc + 1);
    endtask

    typedef struct {
        int          nb;
        logic [79:0] b;
        int          gap;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vt[5];

    initial begin
        int n;
        vt[0] = '{10, 80'h0002_11223344_AABBCCDD, 9, 2,
                  32'h11223344, 32'hAABBCCDD, 1'b1, 1'b0};
        vt[1] = '{10, 80'h0002_11223344_AABBCCDD, 0, 2,
                  32'h11223344, 32'hAABBCCDD, 1'b1, 1'b0};
        vt[2] = '{2, {16'h0000, 64'h0}, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[3] = '{2, {16'h3E81, 64'h0}, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[4] = '{6, {48'h0001_DEADBEEF, 32'h0}, 1, 1,
                  32'hDEADBEEF, 32'h0, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        chk("rst we", write_enable, 0);
        chk("rst addr", address, 0);
        chk("rst wdata", write_data, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        reset = 1'b0;
        tick();

        // Bytes while idle must not disturb anything.
        clear_mon();
        idle_bytes(3);
        chk("idle nwr", wr_data.size(), 0);
        chk("idle busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            stim.delete();
            for (int i = 0; i < vt[v].nb; i++)
                stim.push_back(vt[v].b[79 - 8 * i -: 8]);
            do_load(vt[v].gap);
            chk($sformatf("vec%0d nwr", v), wr_data.size(), vt[v].nw);
            if (vt[v].nw > 0)
                chk($sformatf("vec%0d w0", v), wr_data[0], vt[v].w0);
            if (vt[v].nw > 1)
                chk($sformatf("vec%0d w1", v), wr_data[1], vt[v].w1);
            chk($sformatf("vec%0d done", v), done, vt[v].dn);
            chk($sformatf("vec%0d error", v), error, vt[v].er);
            check_model($sformatf("vec%0d", v));
        end

        // Reset in the middle of the second word.
        stim = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        clear_mon();
        do_start();
        send_range(0, 8, 1);
        chk("midrst nwr", wr_data.size(), 1);
        chk("midrst w0", wr_data[0], 32'h01020304);
        chk("midrst busy pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst we", write_enable, 0);
        chk("midrst addr", address, 0);
        chk("midrst wdata", write_data, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst error", error, 0);
        tick();
        reset = 1'b0;
        tick();
        stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_load(0);
        chk("postrst w0", wr_data[0], 32'hDEADBEEF);
        check_model("postrst");

        // Oversize header, trailing bytes ignored, start clears error.
        stim = '{8'h3E, 8'h81};
        do_load(0);
        check_model("ovr");
        clear_mon();
        idle_bytes(6);
        chk("ovr tail nwr", wr_data.size(), 0);
        chk("ovr tail error", error, 1);
        chk("ovr tail busy", busy, 0);
        do_start();
        chk("ovr clr error", error, 0);
        chk("ovr clr busy", busy, 1);
        stim = '{8'h00, 8'h00};
        send_range(0, 2, 0);
        repeat (3) tick();
        chk("ovr zero done", done, 1);

        // Reload after completion with stray bytes first.
        clear_mon();
        idle_bytes(4);
        chk("reload stray nwr", wr_data.size(), 0);
        chk("reload stray done", done, 1);
        stim = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        clear_mon();
        do_start();
        chk("reload done clr", done, 0);
        chk("reload busy set", busy, 1);
        send_range(0, stim.size(), 2);
        repeat (4) tick();
        chk("reload w0", wr_data[0], 32'hCAFEF00D);
        check_model("reload");

        // A start pulse in the middle of a load is ignored.
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        clear_mon();
        do_start();
        send_range(0, 3, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_range(3, 6, 1);
        repeat (4) tick();
        check_model("midstart");

        // Random streams.
        for (int r = 0; r < 25; r++) begin
            stim.delete();
            if ($urandom_range(0, 5) == 0) begin
                n = int'($urandom_range(16001, 65535));
                stim.push_back(8'(n >> 8));
                stim.push_back(8'(n));
            end else begin
                n = int'($urandom_range(0, 4));
                stim.push_back(8'(n >> 8));
                stim.push_back(8'(n));
                for (int i = 0; i < 4 * n; i++)
                    stim.push_back(8'($urandom));
            end
            do_load(-1);
            check_model($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
